// File: rtl/rsp_proc.sv
// Read-response serializer: frames {HDR_TAG, addr} then data MSB-first to the host.
// Define RSP_CHECKSUM_EN to append an XOR checksum byte (6-byte frames).
module rsp_proc #(
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        REQ_VALID,
  input  logic [3:0]  REQ_ADDR,
  input  logic [31:0] REQ_DATA,
  output logic        REQ_READY,
  output logic        HOST_RTS,
  output logic [7:0]  HOST_DATA,
  input  logic        HOST_RTR,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_D3   = 3'd2,
    S_D2   = 3'd3,
    S_D1   = 3'd4,
    S_D0   = 3'd5
`ifdef RSP_CHECKSUM_EN
    ,S_CKS = 3'd6
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        host_rts;
  logic [7:0]  host_data;
  logic [7:0]  hdr_byte;

  assign hdr_byte = {HDR_TAG, addr_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 4'h0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    host_rts  = 1'b0;
    host_data = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          state_d = S_HDR;
          addr_d  = REQ_ADDR;
          data_d  = REQ_DATA;
        end
      end
      S_HDR: begin
        host_rts  = 1'b1;
        host_data = hdr_byte;
        if (HOST_RTR) state_d = S_D3;
      end
      S_D3: begin
        host_rts  = 1'b1;
        host_data = data_q[31:24];
        if (HOST_RTR) state_d = S_D2;
      end
      S_D2: begin
        host_rts  = 1'b1;
        host_data = data_q[23:16];
        if (HOST_RTR) state_d = S_D1;
      end
      S_D1: begin
        host_rts  = 1'b1;
        host_data = data_q[15:8];
        if (HOST_RTR) state_d = S_D0;
      end
      S_D0: begin
        host_rts  = 1'b1;
        host_data = data_q[7:0];
`ifdef RSP_CHECKSUM_EN
        if (HOST_RTR) state_d = S_CKS;
`else
        if (HOST_RTR) state_d = S_IDLE;
`endif
      end
`ifdef RSP_CHECKSUM_EN
      S_CKS: begin
        host_rts  = 1'b1;
        host_data = hdr_byte ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
        if (HOST_RTR) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is gated by reset directly so it reads 0 for the whole reset pulse.
  assign REQ_READY = (state_q == S_IDLE) && !reset;
  assign BUSY      = (state_q != S_IDLE);
  assign HOST_RTS  = host_rts;
  assign HOST_DATA = host_data;

endmodule
